layer1_param_loader: RTL and testbench

- Sequences the loading of Layer 1 parameters (one bias beat, then one weight beat per pixel address) from a host stream into the Layer 1 weight storage and pStore bias registers.
- Interlocks with the Layer 1 inference controller: no load starts until Layer 1 is idle, and inference wakeup is held off until the load completes.
- Sits between the host/config bus and the Layer 1 controller's weightWriteEnable/biasWriteEnable/WriteAddressSelect/writeIn inputs.

---
 rtl/layer1_param_loader.sv | 190 +++++++++++++++++++
 tb/tb_layer1_param_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/layer1_param_loader.sv
// rtl/layer1_param_loader.sv - Layer 1 bias/weight parameter load sequencer with inference interlock.
// Optional beat checksum verification is built when LAYER1_LOADER_CHECKSUM_EN is defined.
module layer1_param_loader #(
   parameter int NODES       = 10,
   parameter int WEIGHT_BITS = 8,
   parameter int NUM_ADDR    = 784,
   parameter int ADDR_W      = 10
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          cfg_start,
   input  logic                          cfg_valid,
   output logic                          cfg_ready,
   input  logic [NODES*WEIGHT_BITS-1:0]  cfg_data,
   input  logic                          cfg_abort,
   input  logic [15:0]                   cfg_checksum,
   input  logic                          layer_idle,
   output logic                          hold_inference,
   output logic                          weight_we,
   output logic                          bias_we,
   output logic [ADDR_W-1:0]             wr_addr,
   output logic [NODES*WEIGHT_BITS-1:0]  wr_data,
   output logic                          load_done,
   output logic                          load_aborted,
   output logic                          checksum_err
);

   localparam int DATA_W = NODES * WEIGHT_BITS;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ADDR - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_IDLE,
      S_BIAS,
      S_WEIGHTS,
      S_DONE
   } stateT;

   stateT             state;
   stateT             nextState;
   logic [ADDR_W-1:0] beatCount;
   logic              abortHit;
   logic              beatTaken;
   logic              startTaken;
   logic              enterBias;

   assign cfg_ready = (state == S_BIAS) || (state == S_WEIGHTS);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Abort outranks acceptance, so a beat offered alongside abort is dropped.
   always_comb begin
      nextState  = state;
      abortHit   = 1'b0;
      beatTaken  = 1'b0;
      startTaken = 1'b0;
      enterBias  = 1'b0;
      case (state)
         S_IDLE: begin
            if (cfg_start) begin
               startTaken = 1'b1;
               nextState  = S_WAIT_IDLE;
            end
         end
         S_WAIT_IDLE: begin
            if (cfg_abort) begin
               abortHit  = 1'b1;
               nextState = S_IDLE;
            end else if (layer_idle) begin
               enterBias = 1'b1;
               nextState = S_BIAS;
            end
         end
         S_BIAS: begin
            if (cfg_abort) begin
               abortHit  = 1'b1;
               nextState = S_IDLE;
            end else if (cfg_valid) begin
               beatTaken = 1'b1;
               nextState = S_WEIGHTS;
            end
         end
         S_WEIGHTS: begin
            if (cfg_abort) begin
               abortHit  = 1'b1;
               nextState = S_IDLE;
            end else if (cfg_valid) begin
               beatTaken = 1'b1;
               if (beatCount == LAST_ADDR) begin
                  nextState = S_DONE;
               end
            end
         end
         S_DONE: begin
            nextState = S_IDLE;
         end
         default: begin
            nextState = S_IDLE;
         end
      endcase
   end

   // Hold stays high through DONE so the final weight write lands before inference resumes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_inference <= 1'b0;
         weight_we      <= 1'b0;
         bias_we        <= 1'b0;
         wr_addr        <= '0;
         wr_data        <= '0;
         load_done      <= 1'b0;
         load_aborted   <= 1'b0;
         beatCount      <= '0;
      end else begin
         weight_we    <= 1'b0;
         bias_we      <= 1'b0;
         load_done    <= 1'b0;
         load_aborted <= 1'b0;
         if (startTaken) begin
            hold_inference <= 1'b1;
         end
         if (state == S_DONE) begin
            hold_inference <= 1'b0;
            load_done      <= 1'b1;
         end
         if (abortHit) begin
            hold_inference <= 1'b0;
            load_aborted   <= 1'b1;
            beatCount      <= '0;
         end
         if (beatTaken) begin
            wr_data <= cfg_data;
            if (state == S_BIAS) begin
               bias_we   <= 1'b1;
               wr_addr   <= '0;
               beatCount <= '0;
            end else begin
               weight_we <= 1'b1;
               wr_addr   <= beatCount;
               if (beatCount != LAST_ADDR) begin
                  beatCount <= beatCount + ADDR_W'(1);
               end
            end
         end
      end
   end

`ifdef LAYER1_LOADER_CHECKSUM_EN
   logic [15:0] checksumAcc;

   function automatic logic [15:0] beatSum(input logic [DATA_W-1:0] beat);
      logic [15:0] total;
      total = '0;
      for (int i = 0; i < NODES; i++) begin
         total = total + 16'(beat[i*WEIGHT_BITS +: WEIGHT_BITS]);
      end
      return total;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         checksumAcc  <= '0;
         checksum_err <= 1'b0;
      end else begin
         if (startTaken) begin
            checksum_err <= 1'b0;
         end
         if (enterBias) begin
            checksumAcc <= '0;
         end else if (beatTaken) begin
            checksumAcc <= checksumAcc + beatSum(cfg_data);
         end
         if ((state == S_DONE) && (checksumAcc != cfg_checksum)) begin
            checksum_err <= 1'b1;
         end
      end
   end
`else
   logic unusedChecksum;
   assign unusedChecksum = ^cfg_checksum;
   assign checksum_err   = 1'b0;
`endif

endmodule

// File: tb/tb_layer1_param_loader.sv
// tb/tb_layer1_param_loader.sv - Scoreboard bench for layer1_param_loader.
// Checksum expectations follow LAYER1_LOADER_CHECKSUM_EN.
module tb_layer1_param_loader;
   localparam int NODES = 10;
   localparam int WB    = 8;
   localparam int NA    = 4;
   localparam int AW    = 10;
   localparam int DW    = NODES * WB;

   logic          clk = 1'b0;
   logic          reset;
   logic          cfg_start, cfg_valid, cfg_ready, cfg_abort, layer_idle;
   logic [DW-1:0] cfg_data;
   logic [15:0]   cfg_checksum;
   logic          hold_inference, weight_we, bias_we, load_done, load_aborted, checksum_err;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;

   layer1_param_loader #(.NODES(NODES), .WEIGHT_BITS(WB), .NUM_ADDR(NA), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_abort(cfg_abort),
      .cfg_checksum(cfg_checksum), .layer_idle(layer_idle), .hold_inference(hold_inference),
      .weight_we(weight_we), .bias_we(bias_we), .wr_addr(wr_addr), .wr_data(wr_data),
      .load_done(load_done), .load_aborted(load_aborted), .checksum_err(checksum_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit            isBias;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wrT;

   wrT  expWr[$];
   int  expEvt[$];   // 1 = load_done, 2 = load_aborted
   int  nTests = 0;
   int  nFails = 0;
   wrT  monWr;
   int  monEvt;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      nTests++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (weight_we || bias_we) begin
            check("we_exclusive", {127'd0, weight_we & bias_we}, 128'd0);
            if (expWr.size() == 0) begin
               check("unexpected_write", {127'd0, 1'b1}, 128'd0);
            end else begin
               monWr = expWr.pop_front();
               check("wr_kind_bias", {127'd0, bias_we}, {127'd0, monWr.isBias});
               check("wr_addr", 128'(wr_addr), 128'(monWr.addr));
               check("wr_data", 128'(wr_data), 128'(monWr.data));
            end
         end
         if (load_done || load_aborted) begin
            if (expEvt.size() == 0) begin
               check("unexpected_event", 128'({load_done, load_aborted}), 128'd0);
            end else begin
               monEvt = expEvt.pop_front();
               check("event_kind", 128'({load_done, load_aborted}),
                     (monEvt == 1) ? 128'd2 : 128'd1);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] randBeat();
      logic [DW-1:0] b;
      for (int i = 0; i < NODES; i++) begin
         b[i*WB +: WB] = 8'($urandom_range(0, 255));
      end
      return b;
   endfunction

   // gapMode: 0 back-to-back, 1 alternate idle cycles, 2 random gaps.
   // cutAt: beat index at which to abort (cutIsReset=0) or reset (cutIsReset=1); -1 for none.
   task automatic runLoad(input int idleDelay, input int gapMode, input int cutAt,
                          input bit cutIsReset, input bit badSum);
      logic [DW-1:0] beats[NA+1];
      int            sum;
      int            k;
      int            cycles;
      bit            gapToggle;
      bit            cut;
      logic          rdy;
      logic          expErr;
      sum = 0;
      for (int b = 0; b <= NA; b++) begin
         beats[b] = randBeat();
         for (int j = 0; j < NODES; j++) sum += int'(beats[b][j*WB +: WB]);
      end
      cfg_checksum = 16'(sum + int'(badSum));
      layer_idle   = (idleDelay == 0);
      cfg_start    = 1'b1;
      tick();
      cfg_start = 1'b0;
      @(negedge clk);
      check("hold_after_start", {127'd0, hold_inference}, 128'd1);
      check("chk_err_after_start", {127'd0, checksum_err}, 128'd0);
      if (idleDelay > 0) begin
         cfg_valid = 1'b1;
         cfg_data  = beats[0];
         repeat (idleDelay) begin
            @(negedge clk);
            check("ready_while_busy", {127'd0, cfg_ready}, 128'd0);
         end
         @(posedge clk);
         #1;
         layer_idle = 1'b1;
      end
      k = 0;
      cycles = 0;
      gapToggle = 1'b0;
      cut = 1'b0;
      while (k <= NA && cycles < 200) begin
         if (k == cutAt) begin
            cut = 1'b1;
            if (cutIsReset) begin
               cfg_valid = 1'b0;
               @(negedge clk);
               @(posedge clk);
               #2;
               reset = 1'b1;
               #1;
               check("reset_ctrl_outs", 128'({cfg_ready, weight_we, bias_we, hold_inference,
                     load_done, load_aborted, checksum_err}), 128'd0);
               check("reset_wr_addr", 128'(wr_addr), 128'd0);
               check("reset_wr_data", 128'(wr_data), 128'd0);
               @(posedge clk);
               #1;
               reset = 1'b0;
            end else begin
               cfg_valid = 1'b1;
               cfg_data  = beats[k];
               cfg_abort = 1'b1;
               tick();
               cfg_abort = 1'b0;
               cfg_valid = 1'b0;
               expEvt.push_back(2);
               @(negedge clk);
               check("hold_after_abort", {127'd0, hold_inference}, 128'd0);
               check("ready_after_abort", {127'd0, cfg_ready}, 128'd0);
            end
            break;
         end
         gapToggle = ~gapToggle;
         if ((gapMode == 1 && gapToggle) || (gapMode == 2 && $urandom_range(0, 2) == 0)) begin
            cfg_valid = 1'b0;
            tick();
            cycles++;
            continue;
         end
         cfg_valid = 1'b1;
         cfg_data  = beats[k];
         @(negedge clk);
         rdy = cfg_ready;
         tick();
         cycles++;
         if (rdy) begin
            expWr.push_back('{isBias: (k == 0), addr: (k == 0) ? AW'(0) : AW'(k - 1),
                              data: beats[k]});
            k++;
         end
      end
      cfg_valid = 1'b0;
      if (!cut) begin
         if (k <= NA) begin
            check("load_timeout", 128'(k), 128'(NA + 1));
         end else begin
            expEvt.push_back(1);
            @(negedge clk);
            check("ready_after_last", {127'd0, cfg_ready}, 128'd0);
            check("hold_in_done", {127'd0, hold_inference}, 128'd1);
            @(negedge clk);
            check("hold_released", {127'd0, hold_inference}, 128'd0);
`ifdef LAYER1_LOADER_CHECKSUM_EN
            expErr = badSum;
`else
            expErr = 1'b0;
`endif
            check("checksum_err", {127'd0, checksum_err}, {127'd0, expErr});
         end
      end
      repeat (2) tick();
   endtask

   initial begin
      reset        = 1'b1;
      cfg_start    = 1'b0;
      cfg_valid    = 1'b0;
      cfg_abort    = 1'b0;
      cfg_data     = '0;
      cfg_checksum = '0;
      layer_idle   = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ctrl_outs", 128'({cfg_ready, weight_we, bias_we, hold_inference,
            load_done, load_aborted, checksum_err}), 128'd0);
      check("rst_wr_addr", 128'(wr_addr), 128'd0);
      check("rst_wr_data", 128'(wr_data), 128'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick();

      runLoad(0, 0, -1, 1'b0, 1'b0);
      runLoad(20, 0, -1, 1'b0, 1'b0);
      runLoad(0, 1, -1, 1'b0, 1'b0);
      runLoad(0, 0, 2, 1'b0, 1'b0);
      runLoad(0, 0, -1, 1'b0, 1'b0);
      runLoad(0, 0, 3, 1'b1, 1'b0);
      runLoad(0, 0, -1, 1'b0, 1'b0);
      runLoad(0, 0, -1, 1'b0, 1'b1);
      runLoad(0, 2, -1, 1'b0, 1'b0);

      cfg_abort = 1'b1;
      repeat (2) tick();
      cfg_abort = 1'b0;
      @(negedge clk);
      check("idle_abort_ignored_hold", {127'd0, hold_inference}, 128'd0);

      repeat (20) begin
         runLoad($urandom_range(0, 5), $urandom_range(0, 2),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, NA) : -1,
                 1'b0, 1'($urandom_range(0, 1)));
      end

      repeat (3) tick();
      check("wr_queue_drained", 128'(expWr.size()), 128'd0);
      check("evt_queue_drained", 128'(expEvt.size()), 128'd0);
      $display("[TB] %0d tests run, %0d failed", nTests, nFails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end
endmodule
